// File: rtl/ddr3_req_sched_if.sv
// ddr3_req_sched_if: one direction of the request/acknowledge bus between front-end, scheduler and controller FSM
interface ddr3_req_sched_if #(
  parameter int ADDRS = 28,
  parameter int REQID = 4
);
  logic             req;
  logic             lst;
  logic [REQID-1:0] tid;
  logic [ADDRS-1:0] adr;
  logic             ack;
  logic             err;
  modport master (output req, lst, tid, adr, input ack, err);
  modport slave  (input req, lst, tid, adr, output ack, err);
endinterface

// File: rtl/ddr3_req_sched.sv
// ddr3_req_sched: grants WRITE or READ a whole transaction at a time, with fair run limits and turnaround gaps
module ddr3_req_sched #(
  parameter int ADDRS       = 28,
  parameter int REQID       = 4,
  parameter int MAX_RUN     = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  ddr3_req_sched_if.slave  mem_wr,
  ddr3_req_sched_if.slave  mem_rd,
  ddr3_req_sched_if.master fsm_wr,
  ddr3_req_sched_if.master fsm_rd,
  output logic             sch_dir_o,
  output logic             sch_busy_o
);
  localparam int RW      = $clog2(MAX_RUN + 1);
  localparam int TW      = TURN_CYCLES > 1 ? $clog2(TURN_CYCLES) : 1;
  localparam int TURN_LD = TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0;
  typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;
  state_t           state_q, state_d;
  logic             last_dir_q, last_dir_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
  logic             same, other;
  logic [RW-1:0]    run_inc;
  logic [REQID-1:0] wr_tid, rd_tid;
  logic [ADDRS-1:0] wr_adr, rd_adr;
  assign wr_tid = mem_wr.tid;
  assign rd_tid = mem_rd.tid;
  assign wr_adr = mem_wr.adr;
  assign rd_adr = mem_rd.adr;
  assign fsm_wr.req = mem_wr.req & (state_q == WR);
  assign fsm_wr.lst = mem_wr.lst;
  assign fsm_wr.tid = wr_tid;
  assign fsm_wr.adr = wr_adr;
  assign fsm_rd.req = mem_rd.req & (state_q == RD);
  assign fsm_rd.lst = mem_rd.lst;
  assign fsm_rd.tid = rd_tid;
  assign fsm_rd.adr = rd_adr;
  assign mem_wr.ack = fsm_wr.ack & (state_q == WR);
  assign mem_wr.err = fsm_wr.err & (state_q == WR);
  assign mem_rd.ack = fsm_rd.ack & (state_q == RD);
  assign mem_rd.err = fsm_rd.err & (state_q == RD);
  assign sch_dir_o  = last_dir_q;
  assign sch_busy_o = state_q != IDLE;
  assign same    = last_dir_q ? mem_rd.req : mem_wr.req;
  assign other   = last_dir_q ? mem_wr.req : mem_rd.req;
  assign run_inc = run_cnt_q == RW'(MAX_RUN) ? run_cnt_q : run_cnt_q + 1'b1;
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    run_cnt_d  = run_cnt_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      IDLE: begin
        if (same && (!other || run_cnt_q < RW'(MAX_RUN))) begin
          state_d = last_dir_q ? RD : WR;
        end else if (other) begin
          last_dir_d = !last_dir_q;
          run_cnt_d  = '0;
          turn_cnt_d = TW'(TURN_LD);
          state_d    = TURN_CYCLES > 0 ? TURN : (last_dir_q ? WR : RD);
        end
      end
      // grant is committed once TURN is entered; requests are not re-checked
      TURN: begin
        turn_cnt_d = turn_cnt_q == '0 ? '0 : turn_cnt_q - 1'b1;
        state_d    = turn_cnt_q == '0 ? (last_dir_q ? RD : WR) : TURN;
      end
      WR: begin
        if ((fsm_wr.ack || fsm_wr.err) && mem_wr.lst) begin
          run_cnt_d = run_inc;
          state_d   = IDLE;
        end
      end
      RD: begin
        if ((fsm_rd.ack || fsm_rd.err) && mem_rd.lst) begin
          run_cnt_d = run_inc;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_dir_q <= 1'b0;
      run_cnt_q  <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      run_cnt_q  <= run_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end
endmodule

// File: tb/tb_ddr3_req_sched.sv
// tb_ddr3_req_sched: vector table, directed corner sequences and a randomized run against a reference model
module tb_ddr3_req_sched;
  localparam int MAX_RUN     = 4;
  localparam int TURN_CYCLES = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sch_dir, sch_busy;
  always #5 clock = ~clock;
  ddr3_req_sched_if #(.ADDRS(28), .REQID(4)) mem_wr ();
  ddr3_req_sched_if #(.ADDRS(28), .REQID(4)) mem_rd ();
  ddr3_req_sched_if #(.ADDRS(28), .REQID(4)) fsm_wr ();
  ddr3_req_sched_if #(.ADDRS(28), .REQID(4)) fsm_rd ();
  ddr3_req_sched #(.ADDRS(28), .REQID(4), .MAX_RUN(MAX_RUN), .TURN_CYCLES(TURN_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .fsm_wr(fsm_wr), .fsm_rd(fsm_rd),
    .sch_dir_o(sch_dir), .sch_busy_o(sch_busy)
  );
  // in  = {wr_req, wr_lst, rd_req, rd_lst, fsm_wrack, fsm_wrerr, fsm_rdack, fsm_rderr}
  // exp = {fsm_wrreq, fsm_rdreq, mem_wrack, mem_rdack, mem_rderr, sch_dir, sch_busy}
  typedef struct packed {
    logic [7:0] in;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[19];
  int n_vec = 0;
  int n_err = 0;
  int got[$];
  int m_phase, m_left, m_dir, m_run;
  logic       u_act[2];
  int         u_beats[2];
  logic [3:0] u_tid[2];
  logic [27:0] u_adr[2];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clock);
    #1;
  endtask
  task automatic set_in(input logic [7:0] v);
    {mem_wr.req, mem_wr.lst, mem_rd.req, mem_rd.lst, fsm_wr.ack, fsm_wr.err, fsm_rd.ack, fsm_rd.err} = v;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    set_in(8'h00);
    cyc;
    cyc;
    reset = 1'b0;
  endtask
  function automatic logic [6:0] obs;
    return {fsm_wr.req, fsm_rd.req, mem_wr.ack, mem_rd.ack, mem_rd.err, sch_dir, sch_busy};
  endfunction
  initial begin
    logic g[2], req[2], lst[2], done[2], a;
    int t;
    tbl[0]  = '{8'b1100_0000, 7'b0000000};
    tbl[1]  = '{8'b1100_0000, 7'b1000001};
    tbl[2]  = '{8'b1100_0000, 7'b1000001};
    tbl[3]  = '{8'b1100_0000, 7'b1000001};
    tbl[4]  = '{8'b1100_0000, 7'b1000001};
    tbl[5]  = '{8'b1100_1000, 7'b1010001};
    tbl[6]  = '{8'b0011_0000, 7'b0000000};
    tbl[7]  = '{8'b0011_0010, 7'b0000011};
    tbl[8]  = '{8'b0011_0000, 7'b0000011};
    tbl[9]  = '{8'b0011_1000, 7'b0100011};
    tbl[10] = '{8'b0011_0001, 7'b0100111};
    tbl[11] = '{8'b0000_0000, 7'b0000010};
    tbl[12] = '{8'b1110_0000, 7'b0000010};
    tbl[13] = '{8'b1110_0010, 7'b0101011};
    tbl[14] = '{8'b1111_0010, 7'b0101011};
    tbl[15] = '{8'b1100_0000, 7'b0000010};
    tbl[16] = '{8'b1100_0000, 7'b0000001};
    tbl[17] = '{8'b1100_0000, 7'b0000001};
    tbl[18] = '{8'b1100_0000, 7'b1000001};
    set_in(8'h00);
    mem_wr.tid = 4'd3;  mem_wr.adr = 28'h0123;
    mem_rd.tid = 4'd9;  mem_rd.adr = 28'h0abcdef;
    @(negedge clock);
    chk("reset_state", {sch_busy, sch_dir, fsm_wr.req, fsm_rd.req}, 4'b0000);
    do_reset;
    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].in);
      @(negedge clock);
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
      if (i == 1) begin
        chk("wr_tid_fwd", fsm_wr.tid, 4'd3);
        chk("wr_adr_fwd", fsm_wr.adr, 28'h0123);
      end
      cyc;
    end
    // both directions saturated: run limit must alternate 4 and 4
    do_reset;
    set_in(8'b1111_1010);
    t = 0;
    while (got.size() < 12 && t < 200) begin
      @(negedge clock);
      chk("excl", fsm_wr.req & fsm_rd.req, 1'b0);
      if (mem_wr.ack) got.push_back(0);
      if (mem_rd.ack) got.push_back(1);
      cyc;
      t++;
    end
    chk("run_count", got.size(), 12);
    for (int i = 0; i < got.size(); i++) chk($sformatf("run_order%0d", i), got[i], (i >= 4 && i < 8) ? 1 : 0);
    // 4-beat write with read pending and spurious read acks
    do_reset;
    set_in(8'b1011_0000);
    for (int b = 1; b <= 4; b++) begin
      mem_wr.lst = (b == 4);
      t = 0;
      @(negedge clock);
      while (!fsm_wr.req && t < 8) begin
        cyc;
        @(negedge clock);
        t++;
      end
      chk("beat_grant", fsm_wr.req, 1'b1);
      fsm_wr.ack = 1'b1;
      fsm_rd.ack = 1'b1;
      #1;
      chk("beat_wrack", mem_wr.ack, 1'b1);
      chk("spur_rdack", mem_rd.ack, 1'b0);
      chk("rd_blocked", fsm_rd.req, 1'b0);
      cyc;
      fsm_wr.ack = 1'b0;
      fsm_rd.ack = 1'b0;
    end
    mem_wr.req = 1'b0;
    mem_wr.lst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("rd_wait_turn", fsm_rd.req, 1'b0);
      cyc;
    end
    @(negedge clock);
    chk("rd_after_turn", {fsm_rd.req, sch_dir}, 2'b11);
    cyc;
    // reset in the middle of a write
    do_reset;
    set_in(8'b1000_0000);
    cyc;
    @(negedge clock);
    chk("wr_granted", fsm_wr.req, 1'b1);
    cyc;
    reset = 1'b1;
    cyc;
    @(negedge clock);
    chk("rst_mid_wr", {fsm_wr.req, sch_busy, sch_dir}, 3'b000);
    // reset in the middle of a read, after direction flipped
    do_reset;
    set_in(8'b0010_0000);
    t = 0;
    @(negedge clock);
    while (!fsm_rd.req && t < 10) begin
      cyc;
      @(negedge clock);
      t++;
    end
    chk("rd_granted", {fsm_rd.req, sch_dir}, 2'b11);
    cyc;
    reset = 1'b1;
    cyc;
    @(negedge clock);
    chk("rst_mid_rd", {fsm_rd.req, mem_rd.ack, sch_busy, sch_dir}, 4'b0000);
    // randomized traffic against the transaction-level model
    do_reset;
    m_phase = 0; m_left = 0; m_dir = 0; m_run = 0;
    for (int d = 0; d < 2; d++) begin
      u_act[d] = 1'b0; u_beats[d] = 0; u_tid[d] = '0; u_adr[d] = '0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!u_act[d] && $urandom_range(3) == 0) begin
          u_act[d]   = 1'b1;
          u_beats[d] = int'($urandom_range(4, 1));
          u_tid[d]   = 4'($urandom);
          u_adr[d]   = 28'($urandom);
        end
        req[d] = u_act[d];
        lst[d] = u_act[d] && u_beats[d] == 1;
      end
      mem_wr.req = req[0]; mem_wr.lst = lst[0]; mem_wr.tid = u_tid[0]; mem_wr.adr = u_adr[0];
      mem_rd.req = req[1]; mem_rd.lst = lst[1]; mem_rd.tid = u_tid[1]; mem_rd.adr = u_adr[1];
      a = $urandom_range(2) == 0;
      fsm_wr.ack = a;
      fsm_wr.err = !a && $urandom_range(7) == 0;
      a = $urandom_range(2) == 0;
      fsm_rd.ack = a;
      fsm_rd.err = !a && $urandom_range(7) == 0;
      @(negedge clock);
      g[0] = m_phase == 2 && m_dir == 0;
      g[1] = m_phase == 2 && m_dir == 1;
      chk("rand_status",
          {fsm_wr.req, fsm_rd.req, mem_wr.ack, mem_wr.err, mem_rd.ack, mem_rd.err, sch_dir, sch_busy},
          {req[0] & g[0], req[1] & g[1], fsm_wr.ack & g[0], fsm_wr.err & g[0],
           fsm_rd.ack & g[1], fsm_rd.err & g[1], m_dir == 1, m_phase != 0});
      chk("rand_wr_fwd", {fsm_wr.lst, fsm_wr.tid, fsm_wr.adr}, {lst[0], u_tid[0], u_adr[0]});
      chk("rand_rd_fwd", {fsm_rd.lst, fsm_rd.tid, fsm_rd.adr}, {lst[1], u_tid[1], u_adr[1]});
      done[0] = g[0] && (fsm_wr.ack || fsm_wr.err);
      done[1] = g[1] && (fsm_rd.ack || fsm_rd.err);
      case (m_phase)
        0: begin
          if (req[m_dir] && (!req[1-m_dir] || m_run < MAX_RUN)) m_phase = 2;
          else if (req[1-m_dir]) begin
            m_dir = 1 - m_dir;
            m_run = 0;
            m_left = TURN_CYCLES;
            m_phase = TURN_CYCLES > 0 ? 1 : 2;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: begin
          if (done[m_dir] && lst[m_dir]) begin
            m_run = m_run < MAX_RUN ? m_run + 1 : MAX_RUN;
            m_phase = 0;
          end
        end
      endcase
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          u_beats[d]--;
          if (u_beats[d] == 0) u_act[d] = 1'b0;
        end
      end
      cyc;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
